multicycle_chunk_adder: RTL

//   Parametrised successor to the single-bit half adder. Adds or subtracts two

---
 rtl/multicycle_chunk_adder.sv | 134 +++++++++++++
 1 files changed

// File: rtl/multicycle_chunk_adder.sv
// multicycle_chunk_adder
// Adds or subtracts two WIDTH-bit operands CHUNK bits per clock, LSB chunk
// first, carrying between chunks in a register. One operation in flight;
// valid/ready handshakes on both the operand and the result side.
module multicycle_chunk_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    // A chunk size that does not tile the operand exactly has no meaning.
    if ((WIDTH < 1) || (CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
        $error("multicycle_chunk_adder: CHUNK must divide WIDTH exactly");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] op_a, op_b;     // op_b already inverted for subtract
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r, ovf_r;

    logic [CHUNK-1:0] a_chunk, b_chunk;
    logic [CHUNK:0]   chunk_res;
    logic             last_chunk;
    logic             accept;

    assign accept     = in_valid && (state == IDLE);
    assign last_chunk = (cnt == CW'(NCHUNK - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: every clocked assignment is non-blocking so all registers
        // update from the same pre-edge values, independent of statement order.
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Next-state and handshake outputs.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_n = RUN;
            end
            RUN: begin
                if (last_chunk) state_n = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Select the current chunk of each operand and add it with the held carry.
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (cnt == CW'(k)) begin
                a_chunk = op_a[k*CHUNK +: CHUNK];
                b_chunk = op_b[k*CHUNK +: CHUNK];
            end
        end
        chunk_res = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry};
    end

    // Operand capture, per-chunk accumulation and final flag latching.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a   <= '0;
            op_b   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_r  <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else if (accept) begin
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            cnt   <= '0;
        end else if (state == RUN) begin
            for (int k = 0; k < NCHUNK; k++) begin
                if (cnt == CW'(k)) sum_r[k*CHUNK +: CHUNK] <= chunk_res[CHUNK-1:0];
            end
            carry <= chunk_res[CHUNK];
            cnt   <= cnt + CW'(1);
            if (last_chunk) begin
                cout_r <= chunk_res[CHUNK];
                // Carry into the MSB is recovered as a^b^sum at that bit.
                ovf_r  <= a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1]
                        ^ chunk_res[CHUNK-1] ^ chunk_res[CHUNK];
            end
        end
    end

    assign sum  = sum_r;
    assign cout = cout_r;
    assign ovf  = ovf_r;

endmodule
